// File: rtl/piezo_alert_sched.sv
// Piezo alert scheduler: arbitrates level alert requests, issues start/abort pulses to the
// tune player, enforces the silent repeat gap and flags a hung player via a watchdog.
module piezo_alert_sched #(
  parameter bit          fast_sim = 1'b1,
  parameter int unsigned GAP_CYC  = 150_000_000,
  parameter int unsigned TMO_CYC  = 200_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       too_fast,
  input  logic       batt_low,
  input  logic       en_steer,
  input  logic       play_done,
  output logic       play_start,
  output logic       play_abort,
  output logic [1:0] play_tune,
  output logic       sched_fault
);

  localparam int unsigned GAP_SCL = fast_sim ? (GAP_CYC / 10_000) : GAP_CYC;
  localparam int unsigned TMO_SCL = fast_sim ? (TMO_CYC / 10_000) : TMO_CYC;
  localparam int unsigned GAP_LIM = (GAP_SCL < 1) ? 1 : GAP_SCL;
  localparam int unsigned TMO_LIM = (TMO_SCL < 1) ? 1 : TMO_SCL;
  localparam int unsigned GAP_W   = $clog2(GAP_LIM + 1);
  localparam int unsigned TMO_W   = $clog2(TMO_LIM + 1);

  localparam logic [GAP_W-1:0] GAP_END = GAP_W'(GAP_LIM - 1);
  localparam logic [TMO_W-1:0] TMO_END = TMO_W'(TMO_LIM - 1);

  localparam logic [1:0] TUNE_NONE = 2'b00;
  localparam logic [1:0] TUNE_FAST = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             start_d, abort_d, fault_d;
  logic [1:0]       tune_d;
  logic [1:0]       sel_c;

  // Fixed-priority request encode
  always_comb begin
    sel_c = TUNE_NONE;
    if (too_fast)      sel_c = TUNE_FAST;
    else if (batt_low) sel_c = 2'b10;
    else if (en_steer) sel_c = 2'b01;
  end

  // Next-state and next-output decode
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    tmo_d   = tmo_q;
    start_d = 1'b0;
    abort_d = 1'b0;
    tune_d  = play_tune;
    fault_d = sched_fault;

    case (state_q)
      S_IDLE: begin
        if (sel_c != TUNE_NONE) begin
          start_d = 1'b1;
          tune_d  = sel_c;
          tmo_d   = '0;
          state_d = S_PLAY;
        end
      end

      S_PLAY: begin
        if (tmo_q != TMO_END) tmo_d = tmo_q + TMO_W'(1);
        // A finishing tune beats both preemption and the watchdog
        if (play_done) begin
          if (too_fast) begin
            start_d = 1'b1;
            tune_d  = TUNE_FAST;
            tmo_d   = '0;
          end else begin
            gap_d   = '0;
            state_d = S_GAP;
          end
        end else if (too_fast && (play_tune != TUNE_FAST)) begin
          abort_d = 1'b1;
          start_d = 1'b1;
          tune_d  = TUNE_FAST;
          tmo_d   = '0;
        end else if (tmo_q == TMO_END) begin
          abort_d = 1'b1;
          fault_d = 1'b1;
          tune_d  = TUNE_NONE;
          state_d = S_IDLE;
        end
      end

      S_GAP: begin
        if (gap_q != GAP_END) gap_d = gap_q + GAP_W'(1);
        if (too_fast) begin
          start_d = 1'b1;
          tune_d  = TUNE_FAST;
          tmo_d   = '0;
          state_d = S_PLAY;
        end else if (gap_q == GAP_END) begin
          if (sel_c != TUNE_NONE) begin
            start_d = 1'b1;
            tune_d  = sel_c;
            tmo_d   = '0;
            state_d = S_PLAY;
          end else begin
            tune_d  = TUNE_NONE;
            state_d = S_IDLE;
          end
        end
      end

      default: begin
        tune_d  = TUNE_NONE;
        state_d = S_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      gap_q       <= '0;
      tmo_q       <= '0;
      play_start  <= 1'b0;
      play_abort  <= 1'b0;
      play_tune   <= TUNE_NONE;
      sched_fault <= 1'b0;
    end else begin
      state_q     <= state_d;
      gap_q       <= gap_d;
      tmo_q       <= tmo_d;
      play_start  <= start_d;
      play_abort  <= abort_d;
      play_tune   <= tune_d;
      sched_fault <= fault_d;
    end
  end

endmodule

// File: tb/tb_piezo_alert_sched.sv
// Testbench for piezo_alert_sched: directed scenarios plus a randomized run against a
// timestamp-based reference model of the scheduling rules.
module tb_piezo_alert_sched;

  localparam int GAP = 15000;
  localparam int TMO = 20000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       too_fast = 1'b0;
  logic       batt_low = 1'b0;
  logic       en_steer = 1'b0;
  logic       play_done = 1'b0;
  logic       play_start;
  logic       play_abort;
  logic [1:0] play_tune;
  logic       sched_fault;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  piezo_alert_sched #(
    .fast_sim(1'b1),
    .GAP_CYC (150_000_000),
    .TMO_CYC (200_000_000)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .too_fast   (too_fast),
    .batt_low   (batt_low),
    .en_steer   (en_steer),
    .play_done  (play_done),
    .play_start (play_start),
    .play_abort (play_abort),
    .play_tune  (play_tune),
    .sched_fault(sched_fault)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    too_fast = 0; batt_low = 0; en_steer = 0; play_done = 0;
    rst_n = 0;
    step(); step();
    rst_n = 1;
    step();
  endtask

  task automatic test_reset();
    en_steer = 1;
    step(); step();
    n_cmp++;
    if ({play_start, play_abort, play_tune, sched_fault} !== 5'b0) begin
      n_bad++; $display("FAIL reset_state got %b want 00000", {play_start, play_abort, play_tune, sched_fault});
    end
    rst_n = 1;
    step();
    n_cmp++;
    if ({play_start, play_abort, play_tune} !== 4'b1001) begin
      n_bad++; $display("FAIL reset_release_start got %b want 1001", {play_start, play_abort, play_tune});
    end
    apply_reset();
  endtask

  task automatic test_steer_repeat();
    int bad;
    apply_reset();
    en_steer = 1;
    step();
    n_cmp++;
    if ({play_start, play_abort, play_tune} !== 4'b1001) begin
      n_bad++; $display("FAIL steer_start got %b want 1001", {play_start, play_abort, play_tune});
    end
    step();
    n_cmp++;
    if ({play_start, play_tune} !== 3'b001) begin
      n_bad++; $display("FAIL steer_start_pulse got %b want 001", {play_start, play_tune});
    end
    repeat (488) step();
    play_done = 1;
    step();
    play_done = 0;
    bad = 0;
    for (int i = 0; i < GAP; i++) begin
      if (play_start || play_abort || play_tune !== 2'b01) bad++;
      step();
    end
    n_cmp++;
    if (bad !== 0) begin
      n_bad++; $display("FAIL steer_gap_silence got %0d bad cycles want 0", bad);
    end
    n_cmp++;
    if ({play_start, play_abort, play_tune} !== 4'b1001) begin
      n_bad++; $display("FAIL steer_repeat got %b want 1001", {play_start, play_abort, play_tune});
    end
    en_steer = 0;
    step();
  endtask

  task automatic test_priority();
    int lat;
    apply_reset();
    batt_low = 1; en_steer = 1;
    step();
    n_cmp++;
    if ({play_start, play_tune} !== 3'b110) begin
      n_bad++; $display("FAIL prio_batt got %b want 110", {play_start, play_tune});
    end
    batt_low = 0;
    repeat (10) step();
    play_done = 1;
    step();
    play_done = 0;
    lat = 1;
    while (!play_start && lat < GAP + 1000) begin
      step();
      lat++;
    end
    n_cmp++;
    if (lat !== GAP + 1 || play_tune !== 2'b01) begin
      n_bad++; $display("FAIL prio_then_steer got lat=%0d tune=%b want lat=%0d tune=01", lat, play_tune, GAP + 1);
    end
    en_steer = 0;
    step();
  endtask

  task automatic test_fast_preempt();
    apply_reset();
    en_steer = 1;
    step();
    repeat (5) step();
    too_fast = 1;
    step();
    n_cmp++;
    if ({play_start, play_abort, play_tune} !== 4'b1111) begin
      n_bad++; $display("FAIL fast_preempt got %b want 1111", {play_start, play_abort, play_tune});
    end
    step();
    n_cmp++;
    if ({play_start, play_abort, play_tune} !== 4'b0011) begin
      n_bad++; $display("FAIL fast_preempt_pulse got %b want 0011", {play_start, play_abort, play_tune});
    end
  endtask

  task automatic test_fast_restart();
    for (int k = 0; k < 3; k++) begin
      repeat ($urandom_range(3, 40)) step();
      play_done = 1;
      step();
      play_done = 0;
      n_cmp++;
      if ({play_start, play_abort, play_tune} !== 4'b1011) begin
        n_bad++; $display("FAIL fast_restart%0d got %b want 1011", k, {play_start, play_abort, play_tune});
      end
    end
    too_fast = 0;
    repeat (5) step();
    play_done = 1;
    step();
    play_done = 0;
    n_cmp++;
    if ({play_start, play_abort, play_tune} !== 4'b0011) begin
      n_bad++; $display("FAIL fast_to_gap got %b want 0011", {play_start, play_abort, play_tune});
    end
    // done coincident with too_fast while a lower tune plays
    apply_reset();
    en_steer = 1;
    step();
    repeat (4) step();
    too_fast = 1; play_done = 1;
    step();
    play_done = 0;
    n_cmp++;
    if ({play_start, play_abort, play_tune} !== 4'b1011) begin
      n_bad++; $display("FAIL done_and_fast got %b want 1011", {play_start, play_abort, play_tune});
    end
    apply_reset();
  endtask

  task automatic test_timeout();
    int bad;
    apply_reset();
    en_steer = 1;
    step();
    en_steer = 0;
    bad = 0;
    for (int i = 1; i < TMO; i++) begin
      step();
      if (play_abort || play_start) bad++;
    end
    n_cmp++;
    if (bad !== 0) begin
      n_bad++; $display("FAIL tmo_early got %0d bad cycles want 0", bad);
    end
    step();
    n_cmp++;
    if ({play_start, play_abort, play_tune, sched_fault} !== 5'b01001) begin
      n_bad++; $display("FAIL tmo_abort got %b want 01001", {play_start, play_abort, play_tune, sched_fault});
    end
    step();
    n_cmp++;
    if ({play_start, play_abort, play_tune, sched_fault} !== 5'b00001) begin
      n_bad++; $display("FAIL tmo_idle got %b want 00001", {play_start, play_abort, play_tune, sched_fault});
    end
    batt_low = 1;
    step();
    n_cmp++;
    if ({play_start, play_abort, play_tune, sched_fault} !== 5'b10101) begin
      n_bad++; $display("FAIL tmo_replay got %b want 10101", {play_start, play_abort, play_tune, sched_fault});
    end
    batt_low = 0;
  endtask

  task automatic test_reset_mid();
    en_steer = 1;
    repeat (3) step();
    #2;
    rst_n = 0; en_steer = 0;
    #1;
    n_cmp++;
    if ({play_start, play_abort, play_tune, sched_fault} !== 5'b0) begin
      n_bad++; $display("FAIL async_reset got %b want 00000", {play_start, play_abort, play_tune, sched_fault});
    end
    step(); step();
    rst_n = 1;
    step();
    n_cmp++;
    if ({play_start, play_abort, play_tune, sched_fault} !== 5'b0) begin
      n_bad++; $display("FAIL post_reset_idle got %b want 00000", {play_start, play_abort, play_tune, sched_fault});
    end
    en_steer = 1;
    step();
    n_cmp++;
    if ({play_start, play_abort, play_tune, sched_fault} !== 5'b10010) begin
      n_bad++; $display("FAIL post_reset_start got %b want 10010", {play_start, play_abort, play_tune, sched_fault});
    end
    en_steer = 0;
  endtask

  task automatic test_random();
    int         mode;   // 0 silent/idle, 1 tune sounding, 2 repeat gap
    logic [1:0] m_tune, sel;
    logic       m_fault, e_start, e_abort;
    int         c, t_start, t_done;
    apply_reset();
    mode = 0; m_tune = 2'b00; m_fault = 0; t_start = 0; t_done = 0;
    for (c = 0; c < 18000; c++) begin
      if (too_fast) too_fast = ($urandom_range(0, 99) != 0);
      else          too_fast = ($urandom_range(0, 1999) == 0);
      if ($urandom_range(0, 399) == 0) batt_low = ~batt_low;
      if ($urandom_range(0, 149) == 0) en_steer = ~en_steer;
      play_done = ($urandom_range(0, 199) == 0);

      sel = too_fast ? 2'b11 : batt_low ? 2'b10 : en_steer ? 2'b01 : 2'b00;
      e_start = 0; e_abort = 0;
      if (mode == 0) begin
        if (sel != 0) begin mode = 1; m_tune = sel; e_start = 1; t_start = c + 1; end
      end else if (mode == 1) begin
        if (play_done) begin
          if (too_fast) begin m_tune = 2'b11; e_start = 1; t_start = c + 1; end
          else begin mode = 2; t_done = c; end
        end else if (too_fast && m_tune != 2'b11) begin
          e_abort = 1; e_start = 1; m_tune = 2'b11; t_start = c + 1;
        end else if (c - t_start == TMO - 1) begin
          e_abort = 1; m_fault = 1; m_tune = 2'b00; mode = 0;
        end
      end else begin
        if (too_fast) begin mode = 1; m_tune = 2'b11; e_start = 1; t_start = c + 1; end
        else if (c - t_done == GAP) begin
          if (sel != 0) begin mode = 1; m_tune = sel; e_start = 1; t_start = c + 1; end
          else begin m_tune = 2'b00; mode = 0; end
        end
      end

      step();
      n_cmp++;
      if ({play_start, play_abort, play_tune, sched_fault} !== {e_start, e_abort, m_tune, m_fault}) begin
        n_bad++;
        $display("FAIL random cyc=%0d got %b want %b", c,
                 {play_start, play_abort, play_tune, sched_fault}, {e_start, e_abort, m_tune, m_fault});
      end
    end
    too_fast = 0; batt_low = 0; en_steer = 0; play_done = 0;
  endtask

  initial begin
    test_reset();
    test_steer_repeat();
    test_priority();
    test_fast_preempt();
    test_fast_restart();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
